gemm_drain: RTL and testbench

GEMM_DRAIN -- requirements
Module: gemm_drain

---
 rtl/gemm_drain.sv | 203 ++++++++++++++++++++
 tb/tb_gemm_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_drain.sv
// GEMM output drain: credit-gated issue pipe, DEPTH-entry vector buffer, lane serializer.
// Optional sticky protocol-error flag enabled by defining GEMM_DRAIN_ERR_EN.
`ifndef SFPWIDTH
`define SFPWIDTH 9
`endif

module gemm_drain #(
   parameter int unsigned FORMAT_WIDTH = `SFPWIDTH,
   parameter int unsigned LATENCY      = 4,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_valid,
   input  logic                      issue_size4,
   output logic                      issue_ready,
   input  logic [4*FORMAT_WIDTH-1:0] gemm_real,
   input  logic [4*FORMAT_WIDTH-1:0] gemm_imag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [FORMAT_WIDTH-1:0]   out_real,
   output logic [FORMAT_WIDTH-1:0]   out_imag,
   output logic                      out_last,
   output logic                      err
);

   localparam int unsigned FW = FORMAT_WIDTH;
   localparam int unsigned VW = 4 * FORMAT_WIDTH;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + LATENCY + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_e;

   function automatic logic [FW-1:0] lane_sel(input logic [VW-1:0] v, input logic [1:0] k);
      return v[int'(k) * FW +: FW];
   endfunction

   logic [LATENCY-1:0] pv_q, pv_d;
   logic [LATENCY-1:0] ps_q, ps_d;
   logic [CW-1:0]      inflight_q, inflight_d;
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      nxt_ptr;
   logic [VW-1:0]      mem_re [DEPTH];
   logic [VW-1:0]      mem_im [DEPTH];
   logic               mem_sz [DEPTH];

   state_e             state_q, state_d;
   logic [1:0]         lane_q, lane_d;
   logic [FW-1:0]      out_real_q, out_real_d;
   logic [FW-1:0]      out_imag_q, out_imag_d;
   logic               out_last_q, out_last_d;

   logic               accept;
   logic               tail_v;
   logic               full;
   logic               wr_en;
   logic               xfer;
   logic               free;
   logic [VW-1:0]      nh_re;
   logic [VW-1:0]      nh_im;

   // Credit covers both buffered entries and vectors still inside the GEMM pipe.
   assign issue_ready = (count_q + inflight_q) < CW'(DEPTH);
   assign accept      = issue_valid && issue_ready;
   assign tail_v      = pv_q[LATENCY-1];
   assign full        = (count_q == CW'(DEPTH));
   assign wr_en       = tail_v && !full;
   assign xfer        = out_valid && out_ready;
   assign free        = xfer && out_last_q;

   assign out_valid   = (state_q == S_EMIT);
   assign out_real    = out_real_q;
   assign out_imag    = out_imag_q;
   assign out_last    = out_last_q;

   // Issue pipe and buffer bookkeeping.
   always_comb begin
      pv_d       = (pv_q << 1) | LATENCY'(accept);
      ps_d       = (ps_q << 1) | LATENCY'(issue_size4);
      inflight_d = inflight_q + CW'(accept) - CW'(tail_v);
      count_d    = count_q + CW'(wr_en) - CW'(free);
      wr_ptr_d   = wr_ptr_q + PW'(wr_en);
      rd_ptr_d   = rd_ptr_q + PW'(free);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q       <= '0;
         ps_q       <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         pv_q       <= pv_d;
         ps_q       <= ps_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Vector storage carries no reset; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[wr_ptr_q] <= gemm_real;
         mem_im[wr_ptr_q] <= gemm_imag;
         mem_sz[wr_ptr_q] <= ps_q[LATENCY-1];
      end
   end

   // Serializer next-state; the next head comes from the buffer or from the write in flight.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      out_real_d = out_real_q;
      out_imag_d = out_imag_q;
      out_last_d = out_last_q;
      nxt_ptr    = rd_ptr_q + PW'(1);
      if (count_q > CW'(1)) begin
         nh_re = mem_re[nxt_ptr];
         nh_im = mem_im[nxt_ptr];
      end else begin
         nh_re = gemm_real;
         nh_im = gemm_imag;
      end

      unique case (state_q)
         S_IDLE: begin
            if (wr_en) begin
               state_d    = S_EMIT;
               lane_d     = 2'd3;
               out_real_d = lane_sel(gemm_real, 2'd3);
               out_imag_d = lane_sel(gemm_imag, 2'd3);
               out_last_d = 1'b0;
            end
         end
         S_EMIT: begin
            if (xfer) begin
               if (out_last_q) begin
                  if ((count_q > CW'(1)) || wr_en) begin
                     lane_d     = 2'd3;
                     out_real_d = lane_sel(nh_re, 2'd3);
                     out_imag_d = lane_sel(nh_im, 2'd3);
                     out_last_d = 1'b0;
                  end else begin
                     state_d    = S_IDLE;
                     lane_d     = 2'd0;
                     out_last_d = 1'b0;
                  end
               end else begin
                  lane_d     = lane_q - 2'd1;
                  out_real_d = lane_sel(mem_re[rd_ptr_q], lane_d);
                  out_imag_d = lane_sel(mem_im[rd_ptr_q], lane_d);
                  out_last_d = mem_sz[rd_ptr_q] ? (lane_d == 2'd0) : (lane_d == 2'd2);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lane_q     <= '0;
         out_real_q <= '0;
         out_imag_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         out_real_q <= out_real_d;
         out_imag_q <= out_imag_d;
         out_last_q <= out_last_d;
      end
   end

`ifdef GEMM_DRAIN_ERR_EN
   // Sticky: issue without credit, or a pipe write into a full buffer.
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (issue_valid && !issue_ready) | (tail_v && full);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gemm_drain.sv
// Randomized self-checking bench for gemm_drain against a queue-based model of
// credits, in-flight vectors and the expected sample stream.
module tb_gemm_drain;

   localparam int unsigned FW  = 9;
   localparam int unsigned LAT = 4;
   localparam int unsigned DEP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid, issue_size4, issue_ready;
   logic [4*FW-1:0] gemm_real, gemm_imag;
   logic          out_valid, out_ready, out_last, err;
   logic [FW-1:0] out_real, out_imag;

   gemm_drain #(.FORMAT_WIDTH(FW), .LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_size4(issue_size4), .issue_ready(issue_ready),
      .gemm_real(gemm_real), .gemm_imag(gemm_imag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_real(out_real), .out_imag(out_imag), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;

`ifdef GEMM_DRAIN_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   typedef struct {
      int          due;
      logic        sz;
      logic [35:0] re;
      logic [35:0] im;
   } pend_t;

   typedef struct {
      logic [FW-1:0] re;
      logic [FW-1:0] im;
      logic          last;
   } samp_t;

   pend_t pend[$];
   samp_t expq[$];
   int    nbuf;
   logic  err_m;
   int    cyc;
   int    n_cmp, n_bad, n_acc;
   int    first_valid;
   logic  use_dir;
   logic [35:0] dir_re, dir_im;
   logic [FW-1:0] got_re[$];
   logic          got_last[$];

   function automatic logic [35:0] r36();
      return {4'($urandom()), $urandom()};
   endfunction

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic model_ready();
      return (nbuf + pend.size()) < DEP;
   endfunction

   // Compare every DUT output against the model state for the current cycle.
   task automatic check_outputs();
      chk("issue_ready", 36'(issue_ready), 36'(model_ready()));
      chk("out_valid", 36'(out_valid), 36'(nbuf > 0));
      if (nbuf > 0) begin
         chk("out_real", 36'(out_real), 36'(expq[0].re));
         chk("out_imag", 36'(out_imag), 36'(expq[0].im));
         chk("out_last", 36'(out_last), 36'(expq[0].last));
         if (first_valid < 0) first_valid = cyc;
      end
      chk("err", 36'(err), 36'(err_m));
   endtask

   task automatic cycle(input logic iv, input logic sz, input logic ordy);
      logic  ir;
      pend_t p;
      samp_t s;
      int    n;
      @(negedge clk);
      check_outputs();
      ir          = model_ready();
      issue_valid = iv;
      issue_size4 = sz;
      out_ready   = ordy;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         gemm_real = pend[0].re;
         gemm_imag = pend[0].im;
      end else begin
         gemm_real = r36();
         gemm_imag = r36();
      end
      if (nbuf > 0 && ordy) begin
         s = expq.pop_front();
         got_re.push_back(out_real);
         got_last.push_back(out_last);
         if (s.last) nbuf--;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
         p = pend.pop_front();
         n = p.sz ? 4 : 2;
         for (int k = 0; k < n; k++) begin
            s.re   = p.re[(3 - k) * FW +: FW];
            s.im   = p.im[(3 - k) * FW +: FW];
            s.last = (k == n - 1);
            expq.push_back(s);
         end
         nbuf++;
      end
      if (iv && ir) begin
         p.due = cyc + LAT;
         p.sz  = sz;
         p.re  = use_dir ? dir_re : r36();
         p.im  = use_dir ? dir_im : r36();
         pend.push_back(p);
         n_acc++;
      end else if (iv && ERR_ON) begin
         err_m = 1'b1;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      issue_valid = 1'b0;
      out_ready   = 1'b0;
      #1;
      chk("rst_out_valid", 36'(out_valid), 36'd0);
      chk("rst_out_last", 36'(out_last), 36'd0);
      chk("rst_out_real", 36'(out_real), 36'd0);
      chk("rst_out_imag", 36'(out_imag), 36'd0);
      chk("rst_err", 36'(err), 36'd0);
      pend.delete();
      expq.delete();
      nbuf  = 0;
      err_m = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      cyc++;
   endtask

   task automatic clear_log();
      got_re.delete();
      got_last.delete();
      first_valid = -1;
   endtask

   initial begin
      int t0, acc0, gaps;
      rst = 1'b1; issue_valid = 1'b0; issue_size4 = 1'b0; out_ready = 1'b0;
      gemm_real = '0; gemm_imag = '0;
      cyc = 0; n_cmp = 0; n_bad = 0; n_acc = 0; nbuf = 0; err_m = 1'b0;
      use_dir = 1'b0; dir_re = '0; dir_im = '0; first_valid = -1;

      do_reset();
      chk("post_rst_ready", 36'(issue_ready), 36'd1);

      // Single size4 vector with known lanes.
      clear_log();
      use_dir = 1'b1;
      dir_re  = {9'h101, 9'h0FF, 9'h020, 9'h001};
      dir_im  = {9'h0AA, 9'h155, 9'h003, 9'h1F0};
      t0 = cyc;
      cycle(1'b1, 1'b1, 1'b1);
      use_dir = 1'b0;
      repeat (10) cycle(1'b0, 1'b0, 1'b1);
      chk("s4_count", 36'(got_re.size()), 36'd4);
      if (got_re.size() == 4) begin
         chk("s4_l3", 36'(got_re[0]), 36'h101);
         chk("s4_l2", 36'(got_re[1]), 36'h0FF);
         chk("s4_l1", 36'(got_re[2]), 36'h020);
         chk("s4_l0", 36'(got_re[3]), 36'h001);
         chk("s4_last", 36'({got_last[0], got_last[1], got_last[2], got_last[3]}), 36'b0001);
      end
      chk("s4_latency", 36'(first_valid - t0), 36'd5);

      // Single size2 vector.
      clear_log();
      use_dir = 1'b1;
      dir_re  = {9'h1C3, 9'h07E, 9'h111, 9'h122};
      cycle(1'b1, 1'b0, 1'b1);
      use_dir = 1'b0;
      repeat (10) cycle(1'b0, 1'b0, 1'b1);
      chk("s2_count", 36'(got_re.size()), 36'd2);
      if (got_re.size() == 2) begin
         chk("s2_l3", 36'(got_re[0]), 36'h1C3);
         chk("s2_l2", 36'(got_re[1]), 36'h07E);
         chk("s2_last", 36'({got_last[0], got_last[1]}), 36'b01);
      end

      // Five back-to-back issues with the output stalled.
      acc0 = n_acc;
      repeat (5) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("ovf_accepts", 36'(n_acc - acc0), 36'd4);
      chk("ovf_err", 36'(err), 36'(ERR_ON));
      chk("ovf_ready", 36'(issue_ready), 36'd0);
      repeat (30) cycle(1'b0, 1'b0, 1'b1);

      // Stall toggling mid-vector.
      do_reset();
      clear_log();
      use_dir = 1'b1;
      dir_re  = {9'h0F1, 9'h0E2, 9'h0D3, 9'h0C4};
      cycle(1'b1, 1'b1, 1'b0);
      use_dir = 1'b0;
      repeat (4) cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'(i % 2 == 0));
      chk("stall_count", 36'(got_re.size()), 36'd4);
      if (got_re.size() == 4)
         chk("stall_order", {got_re[0], got_re[1], got_re[2], got_re[3]},
             {9'h0F1, 9'h0E2, 9'h0D3, 9'h0C4});

      // Reset while emitting with two entries buffered.
      repeat (2) cycle(1'b1, 1'b1, 1'b0);
      repeat (6) cycle(1'b0, 1'b0, 1'b0);
      chk("pre_rst_valid", 36'(out_valid), 36'd1);
      do_reset();
      clear_log();
      chk("rel_ready", 36'(issue_ready), 36'd1);
      repeat (12) cycle(1'b0, 1'b0, 1'b1);
      chk("no_stale", 36'(got_re.size()), 36'd0);

      // Continuous size4 stream across pointer wraps.
      clear_log();
      gaps = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         #1;
         if (i >= 5 && !out_valid) gaps++;
      end
      chk("no_bubble", 36'(gaps), 36'd0);
      chk("stream_16", 36'(got_re.size() >= 16), 36'd1);
      repeat (40) cycle(1'b0, 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 7));
      repeat (40) cycle(1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
